// File: rtl/reg_file_pkg.sv
// Shared constants for the byte-lane register file.
package reg_file_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 8;
    localparam int LANE_W    = 8;
endpackage

// File: rtl/reg_file_rdport.sv
// One registered read port: write-first bypass and clear override in front of the output flops.
module reg_file_rdport
    import reg_file_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr_i,
    input  logic                        re_i,
    input  logic [AW-1:0]               raddr_i,
    input  logic [DEPTH-1:0][WIDTH-1:0] mem_i,
    input  logic [DEPTH-1:0]            valid_i,
    input  logic                        wr_en_i,
    input  logic [AW-1:0]               waddr_i,
    input  logic [WIDTH-1:0]            wr_data_i,
    output logic [WIDTH-1:0]            rdata_o,
    output logic                        rvalid_o,
    output logic                        rhit_o
);
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic             rhit_q, rhit_d;

    always_comb begin
        rdata_d  = rdata_q;
        rhit_d   = rhit_q;
        rvalid_d = 1'b0;
        if (re_i) begin
            rvalid_d = 1'b1;
            // clear wins over the bypass; wr_data_i is already lane-merged with old data
            if (clr_i) begin
                rdata_d = '0;
                rhit_d  = 1'b0;
            end else if (wr_en_i && (waddr_i == raddr_i)) begin
                rdata_d = wr_data_i;
                rhit_d  = 1'b1;
            end else begin
                rdata_d = mem_i[raddr_i];
                rhit_d  = valid_i[raddr_i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rhit_q   <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            rhit_q   <= rhit_d;
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
    assign rhit_o   = rhit_q;
endmodule

// File: rtl/reg_file.sv
// Flop-array register file with byte-lane writes, one-cycle clear and two registered read ports.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = $clog2(DEPTH),
    localparam int NB   = WIDTH / LANE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [NB-1:0]    wbe,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re_a,
    input  logic             re_b,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic             rvalid_a,
    output logic             rvalid_b,
    output logic             rhit_a,
    output logic             rhit_b
);
    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [WIDTH-1:0]            wmask;
    logic [WIDTH-1:0]            wr_data;
    logic                        wr_en;

    always_comb begin
        wmask = '0;
        for (int i = 0; i < NB; i++) begin
            wmask[i*LANE_W +: LANE_W] = {LANE_W{wbe[i]}};
        end
        // an all-zero byte enable is a no-op, including the valid bit
        wr_en   = we && (|wbe);
        wr_data = (mem_q[waddr] & ~wmask) | (wdata & wmask);

        mem_d   = mem_q;
        valid_d = valid_q;
        if (clr) begin
            mem_d   = '0;
            valid_d = '0;
        end else if (wr_en) begin
            mem_d[waddr]   = wr_data;
            valid_d[waddr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '0;
            valid_q <= '0;
        end else begin
            mem_q   <= mem_d;
            valid_q <= valid_d;
        end
    end

    reg_file_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rd_a (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (clr),
        .re_i      (re_a),
        .raddr_i   (raddr_a),
        .mem_i     (mem_q),
        .valid_i   (valid_q),
        .wr_en_i   (wr_en),
        .waddr_i   (waddr),
        .wr_data_i (wr_data),
        .rdata_o   (rdata_a),
        .rvalid_o  (rvalid_a),
        .rhit_o    (rhit_a)
    );

    reg_file_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rd_b (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (clr),
        .re_i      (re_b),
        .raddr_i   (raddr_b),
        .mem_i     (mem_q),
        .valid_i   (valid_q),
        .wr_en_i   (wr_en),
        .waddr_i   (waddr),
        .wr_data_i (wr_data),
        .rdata_o   (rdata_b),
        .rvalid_o  (rvalid_b),
        .rhit_o    (rhit_b)
    );
endmodule

// File: tb/tb_reg_file.sv
// Directed scenarios plus randomized traffic against an array-based reference model of reg_file.
module tb_reg_file;
    localparam int W = 16;
    localparam int D = 8;

    logic          clk = 1'b0;
    logic          rst, clr, we, re_a, re_b;
    logic [2:0]    waddr, raddr_a, raddr_b;
    logic [1:0]    wbe;
    logic [W-1:0]  wdata;
    logic [W-1:0]  rdata_a, rdata_b;
    logic          rvalid_a, rvalid_b, rhit_a, rhit_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] m_mem [D];
    logic         m_vld [D];
    logic [W-1:0] m_rd_a, m_rd_b;
    logic         m_rv_a, m_rv_b, m_hit_a, m_hit_b;

    reg_file dut (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wbe(wbe), .wdata(wdata),
        .re_a(re_a), .re_b(re_b), .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
        .rhit_a(rhit_a), .rhit_b(rhit_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reads see the write of the same cycle; clear blanks both reads and storage.
    task automatic model_read(input logic [2:0] a, output logic [W-1:0] d, output logic h);
        d = m_mem[a];
        h = m_vld[a];
        if (clr) begin
            d = '0;
            h = 1'b0;
        end else if (we && wbe != 0 && waddr == a) begin
            for (int i = 0; i < W/8; i++)
                if (wbe[i]) d[8*i +: 8] = wdata[8*i +: 8];
            h = 1'b1;
        end
    endtask

    task automatic model_step();
        logic [W-1:0] d;
        logic         h;
        if (rst) begin
            for (int k = 0; k < D; k++) begin m_mem[k] = '0; m_vld[k] = 1'b0; end
            m_rd_a = '0; m_rd_b = '0; m_rv_a = 0; m_rv_b = 0; m_hit_a = 0; m_hit_b = 0;
            return;
        end
        m_rv_a = re_a;
        m_rv_b = re_b;
        if (re_a) begin model_read(raddr_a, d, h); m_rd_a = d; m_hit_a = h; end
        if (re_b) begin model_read(raddr_b, d, h); m_rd_b = d; m_hit_b = h; end
        if (clr) begin
            for (int k = 0; k < D; k++) begin m_mem[k] = '0; m_vld[k] = 1'b0; end
        end else if (we && wbe != 0) begin
            for (int i = 0; i < W/8; i++)
                if (wbe[i]) m_mem[waddr][8*i +: 8] = wdata[8*i +: 8];
            m_vld[waddr] = 1'b1;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("model_rdata_a", rdata_a, m_rd_a);
        chk("model_rdata_b", rdata_b, m_rd_b);
        chk("model_rvalid_a", rvalid_a, m_rv_a);
        chk("model_rvalid_b", rvalid_b, m_rv_b);
        chk("model_rhit_a", rhit_a, m_hit_a);
        chk("model_rhit_b", rhit_b, m_hit_b);
    endtask

    task automatic idle();
        clr = 0; we = 0; waddr = 0; wbe = 0; wdata = 0;
        re_a = 0; re_b = 0; raddr_a = 0; raddr_b = 0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [W-1:0] d, input logic [1:0] be);
        idle();
        we = 1; waddr = a; wdata = d; wbe = be;
        cyc();
    endtask

    initial begin
        int cnt_a, cnt_b;
        for (int k = 0; k < D; k++) begin m_mem[k] = '0; m_vld[k] = 1'b0; end
        idle();
        rst = 1;
        cyc();
        cyc();
        chk("rst_rdata_a", rdata_a, 0);
        chk("rst_rvalid_a", rvalid_a, 0);
        chk("rst_rhit_b", rhit_b, 0);
        rst = 0;

        idle(); re_a = 1; raddr_a = 3;
        cyc();
        chk("rd3_rdata", rdata_a, 16'h0000);
        chk("rd3_rhit", rhit_a, 0);
        chk("rd3_rvalid", rvalid_a, 1);
        idle();
        cyc();
        chk("rd3_pulse_end", rvalid_a, 0);

        wr(3'd2, 16'h1110, 2'b11);
        wr(3'd2, 16'hABCD, 2'b01);
        idle(); re_a = 1; raddr_a = 2;
        cyc();
        chk("lane_merge_rdata", rdata_a, 16'h11CD);
        chk("lane_merge_rhit", rhit_a, 1);

        wr(3'd5, 16'h0011, 2'b11);
        idle(); we = 1; waddr = 5; wdata = 16'hFF00; wbe = 2'b10; re_b = 1; raddr_b = 5;
        cyc();
        chk("bypass_rdata_b", rdata_b, 16'hFF11);
        chk("bypass_rhit_b", rhit_b, 1);

        for (int k = 0; k < D; k++) wr(k[2:0], W'($urandom), 2'b11);
        idle(); clr = 1; we = 1; waddr = 1; wdata = 16'h5A5A; wbe = 2'b11; re_a = 1; raddr_a = 1;
        cyc();
        chk("clr_rdata", rdata_a, 0);
        chk("clr_rhit", rhit_a, 0);
        idle(); re_a = 1; raddr_a = 1;
        cyc();
        chk("post_clr_rdata", rdata_a, 0);
        chk("post_clr_rhit", rhit_a, 0);

        wr(3'd7, 16'h1100, 2'b11);
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 4; k++) begin
            idle(); re_a = 1; re_b = 1; raddr_a = 7; raddr_b = 7;
            cyc();
            chk("dual_same", rdata_a, rdata_b);
            chk("dual_val", rdata_a, 16'h1100);
            cnt_a += int'(rvalid_a);
            cnt_b += int'(rvalid_b);
        end
        chk("dual_pulses_a", cnt_a, 4);
        chk("dual_pulses_b", cnt_b, 4);

        wr(3'd4, 16'h4444, 2'b11);
        idle(); rst = 1; re_a = 1; raddr_a = 4;
        cyc();
        chk("rst_rd_rvalid", rvalid_a, 0);
        chk("rst_rd_rdata", rdata_a, 0);
        rst = 0; idle();
        cyc();
        chk("rst_rel_rdata", rdata_a, 0);
        idle(); re_a = 1; raddr_a = 4;
        cyc();
        chk("rst_rd4_rdata", rdata_a, 0);
        chk("rst_rd4_rhit", rhit_a, 0);

        for (int n = 0; n < 400; n++) begin
            rst     = ($urandom_range(0, 59) == 0);
            clr     = ($urandom_range(0, 19) == 0);
            we      = 1'($urandom_range(0, 1));
            waddr   = 3'($urandom_range(0, 7));
            wbe     = 2'($urandom_range(0, 3));
            wdata   = W'($urandom);
            re_a    = 1'($urandom_range(0, 1));
            re_b    = 1'($urandom_range(0, 1));
            raddr_a = ($urandom_range(0, 2) == 0) ? waddr : 3'($urandom_range(0, 7));
            raddr_b = ($urandom_range(0, 2) == 0) ? waddr : 3'($urandom_range(0, 7));
            cyc();
        end
        rst = 0; idle();
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
